// File: rtl/mem_pkg.sv
// Shared constants, host FSM states and the address decoder for the memory responder.
package mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 12'hFFF;
    localparam logic [ADDR_W-1:0] IO_IN_ADDR  = 12'hFFE;

    typedef enum logic {IDLE, RESP} host_state_t;

    typedef enum logic [1:0] {SRC_RAM, SRC_OUT, SRC_IN} rd_src_t;

    function automatic rd_src_t decode_addr(input logic [ADDR_W-1:0] addr);
        if (addr == IO_OUT_ADDR) return SRC_OUT;
        if (addr == IO_IN_ADDR)  return SRC_IN;
        return SRC_RAM;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor port, host load/debug port and I/O pins of the memory responder.
interface mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              cpu_en;
    logic [ADDR_W-1:0] m_addr;
    logic              m_rw;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_q;
    logic              host_valid;
    logic              host_ready;
    logic              host_rw;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic [DATA_W-1:0] in_port;
    logic [DATA_W-1:0] out_port;

    modport slave (
        input  cpu_en, m_addr, m_rw, m_data,
        input  host_valid, host_rw, host_addr, host_wdata, in_port,
        output m_q, host_ready, host_rdata, host_rvalid, out_port
    );

    modport master (
        output cpu_en, m_addr, m_rw, m_data,
        output host_valid, host_rw, host_addr, host_wdata, in_port,
        input  m_q, host_ready, host_rdata, host_rvalid, out_port
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; read-during-write returns the old word.
module mem_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: RAM plus memory-mapped I/O, shared between the processor
// (cpu_en=1) and a valid/ready host load port (cpu_en=0).
module mem_responder
    import mem_pkg::*;
(
    input logic            clock,
    input logic            reset,
    mem_responder_if.slave bus
);
    host_state_t       r_state, w_state_nxt;
    logic              w_host_ready, w_host_rvalid, w_host_acc;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    rd_src_t           w_dst;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_q, w_read, w_m_q;
    rd_src_t           r_rsrc_p1;
    logic [DATA_W-1:0] r_io_p1;
    logic [DATA_W-1:0] r_out, r_in_s1, r_in_s2;
    logic              r_m_live;
    logic [DATA_W-1:0] r_m_hold, r_host_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_host_ready  = 1'b0;
        w_host_rvalid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_host_ready = !bus.cpu_en;
                if (bus.host_valid && w_host_ready && !bus.host_rw) w_state_nxt = RESP;
            end
            RESP: begin
                w_host_rvalid = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single shared access port: the owner selected by cpu_en drives address and write.
    assign w_host_acc = bus.host_valid && w_host_ready;
    assign w_addr     = bus.cpu_en ? bus.m_addr : bus.host_addr;
    assign w_wr       = bus.cpu_en ? bus.m_rw   : (w_host_acc && bus.host_rw);
    assign w_wdata    = bus.cpu_en ? bus.m_data : bus.host_wdata;
    assign w_dst      = decode_addr(w_addr);
    assign w_ram_we   = w_wr && (w_dst == SRC_RAM);

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock  (clock),
        .i_we   (w_ram_we),
        .i_addr (w_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_ram_q)
    );

    // Read stage p1: remember which source the word comes from, aligned with the RAM output.
    always_ff @(posedge clock) begin
        r_rsrc_p1 <= w_dst;
        r_io_p1   <= (w_dst == SRC_OUT) ? r_out : r_in_s2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_in_s1     <= '0;
            r_in_s2     <= '0;
            r_m_live    <= 1'b0;
            r_m_hold    <= '0;
            r_host_hold <= '0;
        end else begin
            if (w_wr && (w_dst == SRC_OUT)) r_out <= w_wdata;
            r_in_s1  <= bus.in_port;
            r_in_s2  <= r_in_s1;
            r_m_live <= bus.cpu_en;
            r_m_hold <= w_m_q;
            if (w_host_rvalid) r_host_hold <= w_read;
        end
    end

    // m_q follows the fresh read only after a processor-owned edge, otherwise it freezes.
    assign w_read = (r_rsrc_p1 == SRC_RAM) ? w_ram_q : r_io_p1;
    assign w_m_q  = r_m_live ? w_read : r_m_hold;

    assign bus.m_q         = w_m_q;
    assign bus.host_ready  = w_host_ready;
    assign bus.host_rvalid = w_host_rvalid;
    assign bus.host_rdata  = w_host_rvalid ? w_read : r_host_hold;
    assign bus.out_port    = r_out;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected reads, monitor pops on output.
module tb_mem_responder;
    import mem_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_responder dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        host_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rv_count = 0;
    logic [15:0] mem_m [0:4095];
    logic [15:0] out_m = '0;
    logic [15:0] in_m = '0;
    bit          m_resp = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] rd_m(input logic [11:0] a);
        if (a == 12'hFFF) return out_m;
        if (a == 12'hFFE) return in_m;
        return mem_m[a];
    endfunction

    task automatic wr_m(input logic [11:0] a, input logic [15:0] d);
        if (a == 12'hFFF) out_m = d;
        else if (a != 12'hFFE) mem_m[a] = d;
    endtask

    // One clock of stimulus; the model applies the same edge rules at the word level.
    task automatic drive(input bit ce, input bit mrw, input logic [11:0] ma, input logic [15:0] md,
                         input bit hv, input bit hrw, input logic [11:0] ha, input logic [15:0] hd,
                         output bit acc);
        bit er;
        bus.cpu_en = ce;  bus.m_rw = mrw;  bus.m_addr = ma;  bus.m_data = md;
        bus.host_valid = hv;  bus.host_rw = hrw;  bus.host_addr = ha;  bus.host_wdata = hd;
        #1;
        er = !ce && !m_resp;
        chk("host_ready", {31'd0, bus.host_ready}, {31'd0, er});
        acc = 1'b0;
        if (ce) begin
            cpu_q.push_back(exp_t'{cyc + 1, rd_m(ma)});
            if (mrw) wr_m(ma, md);
        end
        if (m_resp) m_resp = 1'b0;
        else if (hv && er) begin
            acc = 1'b1;
            if (hrw) wr_m(ha, hd);
            else begin
                host_q.push_back(exp_t'{cyc + 1, rd_m(ha)});
                m_resp = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit ce, input int n);
        bit a;
        for (int i = 0; i < n; i++) drive(ce, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, a);
    endtask

    // Holds the request until the model says it was taken, bounded to a few cycles.
    task automatic host_req(input bit hrw, input logic [11:0] ha, input logic [15:0] hd);
        bit a;
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, hrw, ha, hd, a);
            if (a) return;
        end
        chk("host_req_accept_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clock) begin
        if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
            chk("m_q", {16'd0, bus.m_q}, {16'd0, cpu_q[0].val});
            void'(cpu_q.pop_front());
        end
        while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
            chk("m_q_missed", 32'd0, 32'd1);
            void'(cpu_q.pop_front());
        end
        if (bus.host_rvalid === 1'b1) begin
            rv_count <= rv_count + 1;
            if (host_q.size() == 0 || host_q[0].due != cyc) begin
                chk("host_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("host_rdata", {16'd0, bus.host_rdata}, {16'd0, host_q[0].val});
                void'(host_q.pop_front());
            end
        end else if (host_q.size() > 0 && host_q[0].due <= cyc) begin
            chk("host_rvalid_missing", 32'd0, 32'd1);
            void'(host_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          a;
        int          rv0;
        logic [11:0] ra;
        reset = 1'b1;
        bus.cpu_en = 1'b0;  bus.m_rw = 1'b0;  bus.m_addr = '0;  bus.m_data = '0;
        bus.host_valid = 1'b0;  bus.host_rw = 1'b0;  bus.host_addr = '0;  bus.host_wdata = '0;
        bus.in_port = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_m_q", {16'd0, bus.m_q}, 32'd0);
        chk("reset_host_rdata", {16'd0, bus.host_rdata}, 32'd0);
        chk("reset_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        chk("reset_out_port", {16'd0, bus.out_port}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // host load then read back
        host_req(1'b1, 12'h005, 16'h1234);
        host_req(1'b1, 12'h020, 16'h0C0C);
        host_req(1'b0, 12'h005, 16'h0);
        idle(1'b0, 1);

        // processor write, read, read-during-write
        drive(1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0, 12'h0, 16'h0, a);
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h0, 16'h0, a);
        drive(1'b1, 1'b1, 12'h010, 16'h1111, 1'b0, 1'b0, 12'h0, 16'h0, a);
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h0, 16'h0, a);

        // output register
        drive(1'b1, 1'b1, 12'hFFF, 16'h00A5, 1'b0, 1'b0, 12'h0, 16'h0, a);
        chk("out_port", {16'd0, bus.out_port}, {16'd0, out_m});
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h0, 16'h0, a);
        host_req(1'b0, 12'hFFF, 16'h0);
        idle(1'b0, 1);

        // input synchroniser: first read sees the old synchronised value
        bus.in_port = 16'h5A5A;
        host_req(1'b0, 12'hFFE, 16'h0);
        idle(1'b0, 2);
        in_m = 16'h5A5A;
        host_req(1'b0, 12'hFFE, 16'h0);
        host_req(1'b1, 12'hFFE, 16'hFFFF);
        host_req(1'b0, 12'hFFE, 16'h0);
        idle(1'b0, 1);
        drive(1'b1, 1'b0, 12'hFFE, 16'h0000, 1'b0, 1'b0, 12'h0, 16'h0, a);

        // ownership: host locked out while the processor runs, processor ignored while halted
        drive(1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b1, 12'h020, 16'hBAD0, a);
        drive(1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b1, 12'h020, 16'hBAD0, a);
        drive(1'b0, 1'b1, 12'h020, 16'hDEAD, 1'b0, 1'b0, 12'h0, 16'h0, a);
        drive(1'b0, 1'b1, 12'h020, 16'hDEAD, 1'b0, 1'b0, 12'h0, 16'h0, a);
        chk("m_q_hold", {16'd0, bus.m_q}, 32'h1111);
        host_req(1'b0, 12'h020, 16'h0);
        idle(1'b0, 1);

        // cpu_en rises during RESP: response completes, held request not taken
        drive(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 12'h005, 16'h0, a);
        drive(1'b1, 1'b0, 12'h005, 16'h0, 1'b1, 1'b0, 12'h005, 16'h0, a);
        drive(1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b0, 12'h005, 16'h0, a);

        // reset while in RESP
        drive(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 12'h005, 16'h0, a);
        bus.host_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        chk("rst_out_port", {16'd0, bus.out_port}, 32'd0);
        chk("rst_m_q", {16'd0, bus.m_q}, 32'd0);
        host_q.delete();
        m_resp = 1'b0;
        out_m = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        host_req(1'b0, 12'h005, 16'h0);
        idle(1'b0, 1);

        // throughput: writes every cycle, reads every other cycle
        for (int i = 0; i < 4; i++) host_req(1'b1, 12'h030 + 12'(i), 16'hA000 + 16'(i * 17));
        rv0 = rv_count;
        for (int i = 0; i < 4; i++) host_req(1'b0, 12'h030 + 12'(i), 16'h0);
        idle(1'b0, 2);
        chk("rvalid_pulses", rv_count - rv0, 32'd4);

        // randomized mixed traffic over a small address pool plus the I/O addresses
        for (int i = 0; i < 16; i++) host_req(1'b1, 12'h100 + 12'(i), 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 17);
            ra = (k < 16) ? 12'h100 + 12'(k) : ((k == 16) ? 12'hFFF : 12'hFFE);
            drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), ra, 16'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  (k < 16) ? 12'h100 + 12'($urandom_range(0, 15)) : ra, 16'($urandom), a);
        end
        idle(1'b0, 3);
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("host_q_drained", host_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
